msk_logic_hpc2_pipe: RTL and testbench

MSK_LOGIC_HPC2_PIPE -- requirements
Module: msk_logic_hpc2_pipe

---
 rtl/msk_logic_hpc2_pipe_if.sv | 30 +++
 rtl/msk_logic_hpc2_pipe.sv | 132 +++++++++++++
 tb/tb_msk_logic_hpc2_pipe.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/msk_logic_hpc2_pipe_if.sv
// Handshake bundle for the masked two-stage HPC2 logic pipeline: operands, randomness and result.
interface msk_logic_hpc2_pipe_if #(
  parameter int unsigned d = 2,
  parameter int unsigned W = 8
);
  localparam int unsigned hpc2rnd = d * (d - 1) / 2;
  localparam int unsigned RW      = W * hpc2rnd;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [W*d-1:0]   ina;
  logic [W*d-1:0]   inb;
  logic             rnd_valid;
  logic             rnd_ready;
  logic [RW-1:0]    rnd;
  logic             out_valid;
  logic             out_ready;
  logic [W*d-1:0]   out;

  modport master (
    output in_valid, in_mode, ina, inb, rnd_valid, rnd, out_ready,
    input  in_ready, rnd_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in_mode, ina, inb, rnd_valid, rnd, out_ready,
    output in_ready, rnd_ready, out_valid, out
  );
endinterface

// File: rtl/msk_logic_hpc2_pipe.sv
// Two-stage HPC2 masked AND/NAND/OR/NOR over W lanes of d-share bits.
// Operand b and randomness enter at S1, operand a is used one cycle later.
module msk_logic_hpc2_pipe #(
  parameter int unsigned d = 2,
  parameter int unsigned W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  msk_logic_hpc2_pipe_if.slave bus
);
  localparam int unsigned hpc2rnd = d * (d - 1) / 2;
  localparam int unsigned RW      = W * hpc2rnd;
  localparam int unsigned WD      = W * d;
  localparam int unsigned NT      = W * d * d;

  // Index of the random bit shared between share domains i and j (i != j).
  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j);
    int unsigned lo, hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

  logic          adv, accept;
  logic          v1_q, v1_d, v2_q, v2_d;
  logic [1:0]    mode1_q, mode1_d, mode2_q, mode2_d;
  logic [WD-1:0] a1_q, a1_d;
  // Per lane, indexed (lane*d + i)*d + j: bx holds b_i on the diagonal and b_j^r_ij elsewhere.
  logic [NT-1:0] bx1_q, bx1_d, r1_q, r1_d;
  logic [NT-1:0] p2_q, p2_d, q2_q, q2_d;
  logic [WD-1:0] b_eff, a_eff, out_w;
  logic [RW-1:0] rnd_w;

  assign rnd_w         = bus.rnd;
  assign adv           = ~v2_q | bus.out_ready;
  assign accept        = bus.in_valid & bus.rnd_valid & adv;
  assign bus.in_ready  = adv;
  assign bus.rnd_ready = bus.in_valid & adv;
  assign bus.out_valid = v2_q;
  assign bus.out       = out_w;

  always_comb begin
    b_eff   = bus.inb;
    a_eff   = a1_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    mode1_d = mode1_q;
    mode2_d = mode2_q;
    a1_d    = a1_q;
    bx1_d   = bx1_q;
    r1_d    = r1_q;
    p2_d    = p2_q;
    q2_d    = q2_q;

    // OR/NOR complement share 0 of both operands before the AND.
    for (int unsigned l = 0; l < W; l++) begin
      b_eff[l*d] = bus.inb[l*d] ^ bus.in_mode[1];
      a_eff[l*d] = a1_q[l*d] ^ mode1_q[1];
    end

    if (adv) begin
      v1_d = accept;
      v2_d = v1_q;
    end
    if (accept) begin
      a1_d    = bus.ina;
      mode1_d = bus.in_mode;
    end
    if (adv && v1_q) begin
      mode2_d = mode1_q;
    end

    for (int unsigned l = 0; l < W; l++) begin
      for (int unsigned i = 0; i < d; i++) begin
        for (int unsigned j = 0; j < d; j++) begin
          int unsigned k;
          k = (l * d + i) * d + j;
          if (accept) begin
            if (i == j) begin
              bx1_d[k] = b_eff[l*d+i];
              r1_d[k]  = 1'b0;
            end else begin
              r1_d[k]  = rnd_w[l*hpc2rnd + pair_idx(i, j)];
              bx1_d[k] = b_eff[l*d+j] ^ rnd_w[l*hpc2rnd + pair_idx(i, j)];
            end
          end
          if (adv && v1_q) begin
            p2_d[k] = a_eff[l*d+i] & bx1_q[k];
            q2_d[k] = ~a_eff[l*d+i] & r1_q[k];
          end
        end
      end
    end
  end

  // Share i of the result is the XOR of domain i's registered terms only.
  always_comb begin
    out_w = '0;
    for (int unsigned l = 0; l < W; l++) begin
      for (int unsigned i = 0; i < d; i++) begin
        for (int unsigned j = 0; j < d; j++) begin
          out_w[l*d+i] = out_w[l*d+i] ^ p2_q[(l*d+i)*d+j] ^ q2_q[(l*d+i)*d+j];
        end
      end
      out_w[l*d] = out_w[l*d] ^ ((mode2_q == 2'd1) | (mode2_q == 2'd2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      mode1_q <= 2'd0;
      mode2_q <= 2'd0;
      a1_q    <= '0;
      bx1_q   <= '0;
      r1_q    <= '0;
      p2_q    <= '0;
      q2_q    <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      mode1_q <= mode1_d;
      mode2_q <= mode2_d;
      a1_q    <= a1_d;
      bx1_q   <= bx1_d;
      r1_q    <= r1_d;
      p2_q    <= p2_d;
      q2_q    <= q2_d;
    end
  end
endmodule

// File: tb/tb_msk_logic_hpc2_pipe.sv
// Bench for msk_logic_hpc2_pipe: vector table, random stream and stall/bubble/reset sequences
// against an unmasked scoreboard.
module tb_msk_logic_hpc2_pipe;
  localparam int unsigned D  = 2;
  localparam int unsigned W  = 8;
  localparam int unsigned RW = W * D * (D - 1) / 2;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    int         acc;
  } sb_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic lat_check;
  logic [7:0] cur_exp;
  sb_t  q[$];
  vec_t vecs[8];

  msk_logic_hpc2_pipe_if #(.d(D), .W(W)) bus ();

  msk_logic_hpc2_pipe #(.d(D), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] m, input logic [7:0] a,
                                       input logic [7:0] b);
    case (m)
      2'd0:    return a & b;
      2'd1:    return ~(a & b);
      2'd2:    return a | b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic logic [7:0] unmask(input logic [W*D-1:0] s);
    logic [7:0] r;
    for (int l = 0; l < W; l++) r[l] = s[l*D] ^ s[l*D+1];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rv, input logic [1:0] m, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] e);
    logic [W*D-1:0] sa, sb;
    logic ma, mb;
    for (int l = 0; l < W; l++) begin
      ma = 1'($urandom_range(0, 1));
      mb = 1'($urandom_range(0, 1));
      sa[l*D+1] = ma;
      sa[l*D]   = a[l] ^ ma;
      sb[l*D+1] = mb;
      sb[l*D]   = b[l] ^ mb;
    end
    bus.in_valid  = v;
    bus.rnd_valid = rv;
    bus.in_mode   = m;
    bus.ina       = sa;
    bus.inb       = sb;
    bus.rnd       = RW'($urandom);
    cur_exp       = e;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 30) begin
      tick();
      k++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  // Monitor: handshakes are sampled on the falling edge, mid-cycle.
  initial begin
    logic          stall_prev;
    logic [W*D-1:0] out_prev;
    sb_t           e;
    stall_prev = 1'b0;
    out_prev   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_out_stable", bus.out, out_prev);
          check("stall_valid_held", bus.out_valid, 1);
        end
        if (bus.out_valid && bus.out_ready) begin
          check("pop_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("result", unmask(bus.out), e.exp);
            if (lat_check) check("latency", cyc - e.acc, 2);
          end
        end
        if (bus.in_valid && bus.rnd_valid && bus.in_ready) q.push_back('{exp: cur_exp, acc: cyc});
        stall_prev = bus.out_valid && !bus.out_ready;
        out_prev   = bus.out;
      end
    end
  end

  initial begin
    logic [1:0] m;
    logic [7:0] a, b;
    int acc_cnt;
    logic [1:0] s4_m[3];
    logic [7:0] s4_a[3], s4_b[3];

    vecs[0] = '{mode: 2'd0, a: 8'hF0, b: 8'h3C, exp: 8'h30};
    vecs[1] = '{mode: 2'd1, a: 8'hA5, b: 8'h0F, exp: 8'hFA};
    vecs[2] = '{mode: 2'd2, a: 8'hA5, b: 8'h0F, exp: 8'hAF};
    vecs[3] = '{mode: 2'd3, a: 8'hA5, b: 8'h0F, exp: 8'h50};
    vecs[4] = '{mode: 2'd0, a: 8'hFF, b: 8'hFF, exp: 8'hFF};
    vecs[5] = '{mode: 2'd3, a: 8'h00, b: 8'h00, exp: 8'hFF};
    vecs[6] = '{mode: 2'd2, a: 8'h00, b: 8'h00, exp: 8'h00};
    vecs[7] = '{mode: 2'd1, a: 8'hFF, b: 8'hFF, exp: 8'h00};

    // Reset with an operation offered: ready is high but nothing is taken.
    rst_n         = 1'b0;
    lat_check     = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 8'h5A, 8'hC3, 8'h42);
    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_rnd_ready", bus.rnd_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    rst_n = 1'b1;
    idle();
    tick();
    tick();
    check("post_rst_out_valid", bus.out_valid, 0);

    // Vector table, one operation at a time.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp);
      tick();
      idle();
      wait_drain();
    end

    // Back-to-back stream of 16 mixed operations.
    for (int i = 0; i < 16; i++) begin
      m = 2'($urandom_range(0, 3));
      a = 8'($urandom);
      b = 8'($urandom);
      drive(1'b1, 1'b1, m, a, b, model(m, a, b));
      #1;
      check("stream_in_ready", bus.in_ready, 1);
      tick();
    end
    idle();
    wait_drain();

    // Back-pressure: three ops offered over five stalled cycles, only two fit.
    lat_check     = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s4_m[i] = 2'($urandom_range(0, 3));
      s4_a[i] = 8'($urandom);
      s4_b[i] = 8'($urandom);
    end
    acc_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, s4_m[acc_cnt], s4_a[acc_cnt], s4_b[acc_cnt],
            model(s4_m[acc_cnt], s4_a[acc_cnt], s4_b[acc_cnt]));
      #1;
      if (bus.in_ready) acc_cnt++;
      tick();
    end
    check("bp_accept_count", acc_cnt, 2);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_rnd_ready", bus.rnd_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    idle();
    wait_drain();
    lat_check = 1'b1;

    // Randomness gap: rnd_valid 1,0,1 yields a bubble between results.
    drive(1'b1, 1'b1, 2'd0, 8'hC6, 8'h5F, 8'h46);
    #1;
    check("gap_rnd_ready0", bus.rnd_ready, 1);
    tick();
    check("gap_ov_c1", bus.out_valid, 0);
    drive(1'b1, 1'b0, 2'd2, 8'h12, 8'h40, 8'h52);
    #1;
    check("gap_rnd_ready1", bus.rnd_ready, 1);
    tick();
    check("gap_ov_c2", bus.out_valid, 1);
    drive(1'b1, 1'b1, 2'd2, 8'h12, 8'h40, 8'h52);
    #1;
    check("gap_rnd_ready2", bus.rnd_ready, 1);
    tick();
    check("gap_ov_bubble", bus.out_valid, 0);
    idle();
    tick();
    check("gap_ov_c4", bus.out_valid, 1);
    wait_drain();

    // Reset with both stages full: in-flight work vanishes.
    lat_check     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 2'd1, 8'h33, 8'h0F, 8'hFC);
    tick();
    drive(1'b1, 1'b1, 2'd3, 8'h81, 8'h18, 8'h66);
    tick();
    idle();
    check("full_out_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out", bus.out, 0);
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    lat_check     = 1'b1;
    drive(1'b1, 1'b1, 2'd2, 8'h0C, 8'h30, 8'h3C);
    tick();
    idle();
    wait_drain();
    repeat (3) tick();
    check("final_out_valid", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
